door_ctrl: RTL and testbench

Parametrised motorised-door controller: the next generation of the team's single-bit button/door FSM. A four-state Moore machine (CLOSED, OPENING, OPEN, CLOSING) with cycle-counted travel and hold timers, an obstruction input that reverses a closing door, and optional lock. It sits between debounced panel inputs and the door motor driver.

---
 rtl/door_ctrl.sv | 104 ++++++++++
 tb/tb_door_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/door_ctrl.sv
// Motorised-door controller: Moore FSM with cycle-counted travel/hold timers and obstruction reversal.
// Optional lock input is enabled by defining DOOR_CTRL_LOCK_EN.
module door_ctrl #(
  parameter int MOVE_TIME = 8,
  parameter int OPEN_TIME = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       obstruct,
`ifdef DOOR_CTRL_LOCK_EN
  input  logic       lock,
`endif
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_open,
  output logic [1:0] state
);

  localparam logic [1:0] S_CLOSED  = 2'd0;
  localparam logic [1:0] S_OPENING = 2'd1;
  localparam logic [1:0] S_OPEN    = 2'd2;
  localparam logic [1:0] S_CLOSING = 2'd3;

  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIME - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_act;
  logic             button_ok;
  logic             activity;

`ifdef DOOR_CTRL_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // A locked door ignores the panel button but still honours the obstruction sensor.
  assign button_ok = button & ~lock_act;
  assign activity  = button_ok | obstruct;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLOSED: begin
        if (button_ok) begin
          state_d = S_OPENING;
          cnt_d   = '0;
        end
      end
      S_OPENING: begin
        if (cnt_q == MOVE_LAST) begin
          state_d = S_OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_OPEN: begin
        if (activity) begin
          cnt_d = '0;
        end else if (cnt_q == OPEN_LAST) begin
          state_d = S_CLOSING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // Reversal wins over completion; reopening only retraces the distance already closed.
        if (activity) begin
          state_d = S_OPENING;
          cnt_d   = MOVE_LAST - cnt_q;
        end else if (cnt_q == MOVE_LAST) begin
          state_d = S_CLOSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLOSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign motor_open  = (state_q == S_OPENING);
  assign motor_close = (state_q == S_CLOSING);
  assign door_open   = (state_q == S_OPEN);

endmodule

// File: tb/tb_door_ctrl.sv
// Self-checking bench for door_ctrl: directed test-plan scenarios plus random traffic
// against a time-remaining reference model of the door.
module tb_door_ctrl;

  localparam int MOVE = 4;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b0;
  logic       obstruct = 1'b0;
  logic       lock = 1'b0;
  logic       motor_open, motor_close, door_open;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  // Reference model: direction of travel, cycles of travel left, hold time left.
  int m_dir = 0;
  int m_travel = 0;
  int m_hold = 0;
  bit m_open = 1'b0;

  door_ctrl #(.MOVE_TIME(MOVE), .OPEN_TIME(HOLD), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .obstruct(obstruct),
`ifdef DOOR_CTRL_LOCK_EN
    .lock(lock),
`endif
    .motor_open(motor_open),
    .motor_close(motor_close),
    .door_open(door_open),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelState();
    if (m_dir > 0) return 1;
    if (m_dir < 0) return 3;
    if (m_open) return 2;
    return 0;
  endfunction

  function automatic void modelReset();
    m_dir = 0;
    m_travel = 0;
    m_hold = 0;
    m_open = 1'b0;
  endfunction

  function automatic void modelStep(input bit b, input bit o, input bit l);
    bit press;
    press = b && !l;
    if (m_dir > 0) begin
      m_travel--;
      if (m_travel == 0) begin
        m_dir = 0;
        m_open = 1'b1;
        m_hold = HOLD;
      end
    end else if (m_dir < 0) begin
      if (press || o) begin
        // Distance already closed, plus the reversing cycle itself.
        m_travel = (MOVE - m_travel) + 1;
        m_dir = 1;
      end else begin
        m_travel--;
        if (m_travel == 0) m_dir = 0;
      end
    end else if (m_open) begin
      if (press || o) begin
        m_hold = HOLD;
      end else begin
        m_hold--;
        if (m_hold == 0) begin
          m_open = 1'b0;
          m_dir = -1;
          m_travel = MOVE;
        end
      end
    end else if (press) begin
      m_dir = 1;
      m_travel = MOVE;
    end
  endfunction

  task automatic checkAgainstModel(input string tag);
    int es;
    es = modelState();
    checkOutput({tag, ".state"}, int'(state), es);
    checkOutput({tag, ".motor_open"}, int'(motor_open), int'(es == 1));
    checkOutput({tag, ".motor_close"}, int'(motor_close), int'(es == 3));
    checkOutput({tag, ".door_open"}, int'(door_open), int'(es == 2));
    checkOutput({tag, ".excl"}, int'(motor_open & motor_close), 0);
  endtask

  task automatic applyStimulus(input bit b, input bit o, input bit l, input string tag);
    @(negedge clk);
    button = b;
    obstruct = o;
`ifdef DOOR_CTRL_LOCK_EN
    lock = l;
`else
    lock = 1'b0;
`endif
    @(posedge clk);
    modelStep(button, obstruct, lock);
    #1;
    checkAgainstModel(tag);
  endtask

  task automatic asyncReset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput({tag, ".rst_state"}, int'(state), 0);
    checkOutput({tag, ".rst_outs"}, int'({motor_open, motor_close, door_open}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runUntil(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (modelState() != target && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, tag);
      n++;
    end
    checkOutput({tag, ".reached"}, modelState(), target);
  endtask

  int exp_seq [12] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0};

  initial begin
    asyncReset("reset");
    applyStimulus(1'b0, 1'b1, 1'b0, "idle_after_reset");
    applyStimulus(1'b0, 1'b0, 1'b0, "idle_after_reset");

    // Full cycle from a single-cycle button pulse, checked against the literal timeline.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b0, "full_cycle");
      checkOutput($sformatf("full_cycle.edge%0d", i), int'(state), exp_seq[i]);
    end

    // Button held in OPEN keeps the door open; closing follows HOLD cycles after release.
    applyStimulus(1'b1, 1'b0, 1'b0, "hold_start");
    runUntil(2, 10, "hold_reach");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, "hold");
    checkOutput("hold.door_open", int'(door_open), 1);
    for (int i = 0; i < HOLD - 1; i++) applyStimulus(1'b0, 1'b0, 1'b0, "hold_release");
    checkOutput("hold.still_open", int'(state), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, "hold_release");
    checkOutput("hold.closing", int'(state), 3);

    // Obstruction one cycle into CLOSING reopens with two cycles of travel.
    applyStimulus(1'b0, 1'b0, 1'b0, "rev_cnt1");
    applyStimulus(1'b0, 1'b1, 1'b0, "rev_hit");
    checkOutput("rev.opening", int'(state), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, "rev_travel");
    checkOutput("rev.not_yet_open", int'(door_open), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, "rev_travel");
    checkOutput("rev.open", int'(door_open), 1);
    runUntil(0, 20, "rev_close");

    // Reset mid-OPENING, then a fresh full opening.
    applyStimulus(1'b1, 1'b0, 1'b0, "mid_open");
    applyStimulus(1'b0, 1'b0, 1'b0, "mid_open");
    applyStimulus(1'b0, 1'b0, 1'b0, "mid_open");
    asyncReset("mid_open_reset");
    checkOutput("mid_open.motor_open", int'(motor_open), 0);
    for (int i = 0; i < MOVE; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b0, "restart");
      checkOutput("restart.motor_open", int'(motor_open), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, "restart");
    checkOutput("restart.door_open", int'(door_open), 1);
    runUntil(0, 20, "restart_close");

`ifdef DOOR_CTRL_LOCK_EN
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, "lock_closed");
    checkOutput("lock_closed.state", int'(state), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, "lock_open");
    runUntil(3, 20, "lock_to_closing");
    for (int i = 0; i < MOVE; i++) applyStimulus(1'b1, 1'b0, 1'b1, "lock_closing_btn");
    checkOutput("lock_closing_btn.state", int'(state), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, "lock_open2");
    runUntil(3, 20, "lock_to_closing2");
    applyStimulus(1'b0, 1'b1, 1'b1, "lock_closing_obs");
    checkOutput("lock_closing_obs.state", int'(state), 1);
    runUntil(0, 30, "lock_close2");
`endif

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        asyncReset("rand_reset");
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) == 0, "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
